// File: rtl/regfile_mp.sv
// Multi-port integer register file: NRP combinational read ports, two prioritised write ports,
// optional write-to-read bypass, a per-register busy scoreboard and a self-clearing init sequence.
module regfile_mp #(
   parameter int XLEN     = 32,
   parameter int NREG     = 32,
   parameter int AW       = 5,
   parameter int NRP      = 3,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRP*AW-1:0]   raddr,
   output logic [NRP*XLEN-1:0] rdata,
   input  logic                w0_en,
   input  logic [AW-1:0]       w0_addr,
   input  logic [XLEN-1:0]     w0_data,
   input  logic                w1_en,
   input  logic [AW-1:0]       w1_addr,
   input  logic [XLEN-1:0]     w1_data,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_addr,
   output logic [NREG-1:0]     busy,
   output logic                init_done
);

   typedef enum logic {CLEAR, RUN} state_t;

   localparam logic [AW:0] CNT_LAST = (AW+1)'(NREG-1);

   state_t          state_q, state_d;
   logic [AW:0]     cnt_q, cnt_d;
   logic            init_done_q, init_done_d;
   logic [NREG-1:0] busy_q, busy_d;
   logic [XLEN-1:0] mem_q [NREG];
   logic [XLEN-1:0] mem_d [NREG];

   logic w0_ok, w1_ok;

   // Writes to entry 0 are dropped entirely when it is hardwired to zero.
   assign w0_ok = w0_en && !((ZERO_REG != 0) && (w0_addr == '0));
   assign w1_ok = w1_en && !((ZERO_REG != 0) && (w1_addr == '0));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      init_done_d = init_done_q;
      busy_d      = busy_q;
      mem_d       = mem_q;
      case (state_q)
         CLEAR: begin
            mem_d[cnt_q[AW-1:0]] = '0;
            cnt_d                = cnt_q + (AW+1)'(1);
            busy_d               = '0;
            if (cnt_q == CNT_LAST) begin
               state_d     = RUN;
               init_done_d = 1'b1;
            end
         end
         default: begin
            // w1 is applied last so it overrides w0 on an address collision.
            if (w0_ok) mem_d[w0_addr] = w0_data;
            if (w1_ok) mem_d[w1_addr] = w1_data;
            if (w0_en) busy_d[w0_addr] = 1'b0;
            if (w1_en) busy_d[w1_addr] = 1'b0;
            if (iss_en) busy_d[iss_addr] = 1'b1;
            if (ZERO_REG != 0) busy_d[0] = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= CLEAR;
         cnt_q       <= '0;
         init_done_q <= 1'b0;
         busy_q      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         init_done_q <= init_done_d;
         busy_q      <= busy_d;
         mem_q       <= mem_d;
      end
   end

   always_comb begin
      logic [AW-1:0] ra;
      rdata = '0;
      ra    = '0;
      for (int k = 0; k < NRP; k++) begin
         ra = raddr[k*AW +: AW];
         if (state_q == RUN) begin
            if ((ZERO_REG != 0) && (ra == '0))
               rdata[k*XLEN +: XLEN] = '0;
            else if ((BYPASS != 0) && w1_en && (w1_addr == ra))
               rdata[k*XLEN +: XLEN] = w1_data;
            else if ((BYPASS != 0) && w0_en && (w0_addr == ra))
               rdata[k*XLEN +: XLEN] = w0_data;
            else
               rdata[k*XLEN +: XLEN] = mem_q[ra];
         end
      end
   end

   assign busy      = busy_q;
   assign init_done = init_done_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: default, no-bypass and 64-bit/16-entry instances.
// Latency: reads checked combinationally, state checked one edge after stimulus.
// Backpressure: none; the DUT has no flow control, stimulus is applied every cycle.
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_ab;
    logic [14:0]   raddr_ab;
    logic [95:0]   rdata_a, rdata_b;
    logic          w0_en, w1_en, iss_en;
    logic [4:0]    w0_addr, w1_addr, iss_addr;
    logic [31:0]   w0_data, w1_data;
    logic [31:0]   busy_a, busy_b;
    logic          init_a, init_b;

    logic          rst_c;
    logic [15:0]   raddr_c;
    logic [255:0]  rdata_c;
    logic          c_w0_en, c_w1_en, c_iss_en;
    logic [3:0]    c_w0_addr, c_w1_addr, c_iss_addr;
    logic [63:0]   c_w0_data, c_w1_data;
    logic [15:0]   busy_c;
    logic          init_c;

    regfile_mp u_a (
        .clk(clk), .rst(rst_ab), .raddr(raddr_ab), .rdata(rdata_a),
        .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data),
        .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy(busy_a), .init_done(init_a)
    );

    regfile_mp #(.BYPASS(0)) u_b (
        .clk(clk), .rst(rst_ab), .raddr(raddr_ab), .rdata(rdata_b),
        .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data),
        .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy(busy_b), .init_done(init_b)
    );

    regfile_mp #(.XLEN(64), .NREG(16), .AW(4), .NRP(4), .ZERO_REG(0)) u_c (
        .clk(clk), .rst(rst_c), .raddr(raddr_c), .rdata(rdata_c),
        .w0_en(c_w0_en), .w0_addr(c_w0_addr), .w0_data(c_w0_data),
        .w1_en(c_w1_en), .w1_addr(c_w1_addr), .w1_data(c_w1_data),
        .iss_en(c_iss_en), .iss_addr(c_iss_addr), .busy(busy_c), .init_done(init_c)
    );

    // kind: 0 = rdata port idx, 1 = busy bit idx, 2 = init_done, 3 = whole busy vector
    typedef struct {
        int          dut;
        int          kind;
        int          idx;
        logic [63:0] exp;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_v(input int dut, input int kind, input int idx,
                            input logic [63:0] exp, input string name);
        exp_t e;
        e.dut = dut; e.kind = kind; e.idx = idx; e.exp = exp; e.name = name;
        exp_q.push_back(e);
    endtask

    function automatic logic [63:0] actual(input exp_t e);
        logic [63:0] v;
        v = '0;
        case (e.dut)
            0: case (e.kind)
                   0: v = 64'(rdata_a[e.idx*32 +: 32]);
                   1: v = 64'(busy_a[e.idx]);
                   2: v = 64'(init_a);
                   default: v = 64'(busy_a);
               endcase
            1: case (e.kind)
                   0: v = 64'(rdata_b[e.idx*32 +: 32]);
                   1: v = 64'(busy_b[e.idx]);
                   2: v = 64'(init_b);
                   default: v = 64'(busy_b);
               endcase
            default: case (e.kind)
                   0: v = rdata_c[e.idx*64 +: 64];
                   1: v = 64'(busy_c[e.idx]);
                   2: v = 64'(init_c);
                   default: v = 64'(busy_c);
               endcase
        endcase
        return v;
    endfunction

    initial begin : monitor
        exp_t        e;
        logic [63:0] act;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = actual(e);
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", e.name, e.dut, act, e.exp);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int port, input int addr);
        raddr_ab[port*5 +: 5] = 5'(addr);
    endtask

    task automatic rdc(input int port, input int addr);
        raddr_c[port*4 +: 4] = 4'(addr);
    endtask

    initial begin : stim
        rst_ab = 1'b1; raddr_ab = '0;
        w0_en = 1'b0; w0_addr = '0; w0_data = '0;
        w1_en = 1'b0; w1_addr = '0; w1_data = '0;
        iss_en = 1'b0; iss_addr = '0;
        rst_c = 1'b1; raddr_c = '0;
        c_w0_en = 1'b0; c_w0_addr = '0; c_w0_data = '0;
        c_w1_en = 1'b0; c_w1_addr = '0; c_w1_data = '0;
        c_iss_en = 1'b0; c_iss_addr = '0;

        step(); step();
        for (int d = 0; d < 2; d++) begin
            expect_v(d, 2, 0, 64'd0, "reset_init_done");
            expect_v(d, 3, 0, 64'd0, "reset_busy");
        end
        rst_ab = 1'b0;
        w0_en = 1'b1; w0_addr = 5'd5; w0_data = 32'hAAAA_5555;
        iss_en = 1'b1; iss_addr = 5'd6;
        rd(0, 5);
        for (int i = 1; i <= 32; i++) begin
            step();
            if (i == 10) begin
                expect_v(0, 0, 0, 64'd0, "clear_rdata_zero");
                expect_v(0, 3, 0, 64'd0, "clear_busy_zero");
            end
            if (i == 20) begin
                w0_en = 1'b0; iss_en = 1'b0;
            end
            if (i == 31) expect_v(0, 2, 0, 64'd0, "init_done_early");
            if (i == 32) begin
                expect_v(0, 2, 0, 64'd1, "init_done_at_32");
                expect_v(1, 2, 0, 64'd1, "init_done_at_32");
                expect_v(0, 3, 0, 64'd0, "busy_after_clear");
            end
        end
        checks++;
        if ((init_a !== 1'b1) || (init_b !== 1'b1)) begin
            errors++;
            $display("FAIL direct_init_done: got a=%b b=%b expected 1", init_a, init_b);
        end
        for (int a = 0; a < 32; a += 3) begin
            for (int k = 0; k < 3; k++) rd(k, (a + k) % 32);
            for (int d = 0; d < 2; d++)
                for (int k = 0; k < 3; k++) expect_v(d, 0, k, 64'd0, "cleared_entry");
            step();
        end

        w0_en = 1'b1; w0_addr = 5'd7; w0_data = 32'hDEAD_BEEF;
        w1_en = 1'b1; w1_addr = 5'd0; w1_data = 32'h1234_5678;
        rd(0, 7); rd(1, 0);
        expect_v(0, 0, 0, 64'hDEAD_BEEF, "bypass_w0_x7");
        expect_v(1, 0, 0, 64'd0, "nobypass_x7_old");
        expect_v(0, 0, 1, 64'd0, "x0_bypass_blocked");
        step();
        w0_en = 1'b0; w1_en = 1'b0;
        expect_v(0, 0, 0, 64'hDEAD_BEEF, "read_x7");
        expect_v(1, 0, 0, 64'hDEAD_BEEF, "read_x7");
        expect_v(0, 0, 1, 64'd0, "read_x0");
        expect_v(1, 0, 1, 64'd0, "read_x0");
        step();

        w0_en = 1'b1; w0_addr = 5'd3; w0_data = 32'h11;
        w1_en = 1'b1; w1_addr = 5'd3; w1_data = 32'h22;
        rd(2, 3);
        expect_v(0, 0, 2, 64'h22, "conflict_bypass");
        expect_v(1, 0, 2, 64'h0, "conflict_nobypass_old");
        step();
        w0_en = 1'b0; w1_en = 1'b0;
        expect_v(0, 0, 2, 64'h22, "conflict_stored");
        expect_v(1, 0, 2, 64'h22, "conflict_stored");
        step();

        iss_en = 1'b1; iss_addr = 5'd9;
        step();
        checks++;
        if (busy_a[9] !== 1'b1) begin
            errors++;
            $display("FAIL direct_busy9_set: got %b expected 1", busy_a[9]);
        end
        iss_en = 1'b0;
        expect_v(0, 1, 9, 64'd1, "busy9_set");
        step();
        iss_en = 1'b1; iss_addr = 5'd9;
        w0_en = 1'b1; w0_addr = 5'd9; w0_data = 32'h1;
        step();
        iss_en = 1'b0; w0_en = 1'b0;
        expect_v(0, 1, 9, 64'd1, "busy9_set_wins");
        step();
        w1_en = 1'b1; w1_addr = 5'd9; w1_data = 32'h2;
        step();
        w1_en = 1'b0;
        expect_v(0, 1, 9, 64'd0, "busy9_cleared_w1");
        iss_en = 1'b1; iss_addr = 5'd0;
        step();
        iss_en = 1'b0;
        expect_v(0, 3, 0, 64'd0, "busy0_never_set");

        for (int r = 1; r <= 4; r++) begin
            w0_en = 1'b1; w0_addr = 5'(r); w0_data = 32'h100 + 32'(r);
            if (r == 4) begin
                iss_en = 1'b1; iss_addr = 5'd2;
            end
            step();
        end
        w0_en = 1'b0; iss_en = 1'b0;
        rd(0, 1); rd(1, 4);
        expect_v(0, 0, 0, 64'h101, "fill_x1");
        expect_v(0, 0, 1, 64'h104, "fill_x4");
        expect_v(0, 1, 2, 64'd1, "fill_busy2");
        rst_ab = 1'b1;
        step();
        checks++;
        if (busy_a !== 32'd0) begin
            errors++;
            $display("FAIL direct_rst_busy: got 0x%0h expected 0", busy_a);
        end
        expect_v(0, 3, 0, 64'd0, "rst_busy_cleared");
        expect_v(0, 2, 0, 64'd0, "rst_init_low");
        rst_ab = 1'b0;
        repeat (16) step();
        rst_ab = 1'b1;
        step();
        expect_v(0, 2, 0, 64'd0, "midclear_rst_init_low");
        rst_ab = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            step();
            if (i == 31) expect_v(0, 2, 0, 64'd0, "reclear_init_early");
            if (i == 32) expect_v(0, 2, 0, 64'd1, "reclear_init_at_32");
        end
        rd(0, 1); rd(1, 2); rd(2, 3);
        for (int k = 0; k < 3; k++) expect_v(0, 0, k, 64'd0, "reclear_entry");
        step();
        rd(0, 4);
        expect_v(0, 0, 0, 64'd0, "reclear_x4");
        step();

        rst_c = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 15) expect_v(2, 2, 0, 64'd0, "c_init_early");
            if (i == 16) expect_v(2, 2, 0, 64'd1, "c_init_at_16");
        end
        checks++;
        if (init_c !== 1'b1) begin
            errors++;
            $display("FAIL direct_c_init: got %b expected 1", init_c);
        end
        c_w0_en = 1'b1; c_w0_addr = 4'd0; c_w0_data = 64'hFFFF_0000_FFFF_0000;
        c_w1_en = 1'b1; c_w1_addr = 4'd1; c_w1_data = 64'h1111_2222_3333_4444;
        c_iss_en = 1'b1; c_iss_addr = 4'd0;
        step();
        c_iss_en = 1'b0;
        expect_v(2, 1, 0, 64'd1, "c_busy0_set");
        c_w0_addr = 4'd2; c_w0_data = 64'hA5A5_A5A5_5A5A_5A5A;
        c_w1_addr = 4'd3; c_w1_data = 64'h0123_4567_89AB_CDEF;
        step();
        c_w0_en = 1'b0; c_w1_en = 1'b0;
        for (int k = 0; k < 4; k++) rdc(k, k);
        expect_v(2, 0, 0, 64'hFFFF_0000_FFFF_0000, "c_x0_writable");
        expect_v(2, 0, 1, 64'h1111_2222_3333_4444, "c_port1");
        expect_v(2, 0, 2, 64'hA5A5_A5A5_5A5A_5A5A, "c_port2");
        expect_v(2, 0, 3, 64'h0123_4567_89AB_CDEF, "c_port3");
        step();
        for (int k = 0; k < 4; k++) rdc(k, 3 - k);
        expect_v(2, 0, 0, 64'h0123_4567_89AB_CDEF, "c_perm_port0");
        expect_v(2, 0, 1, 64'hA5A5_A5A5_5A5A_5A5A, "c_perm_port1");
        expect_v(2, 0, 2, 64'h1111_2222_3333_4444, "c_perm_port2");
        expect_v(2, 0, 3, 64'hFFFF_0000_FFFF_0000, "c_perm_port3");
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the next-generation core.
- Provides NRP combinational read ports, two prioritised write ports, and optional same-cycle write-to-read bypass.
- Carries a per-register busy scoreboard for in-flight destinations.
- Owns its own initialisation: a clear sequencer zeroes every entry after reset.
- Sits between decode (reads, issue) and the writeback stages (two writers, e.g. ALU and LSU).

Parameters:
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers (power of two, >= 2)
- AW, 5, address width; must equal log2(NREG)
- NRP, 3, number of read ports
- ZERO_REG, 1, 1 = entry 0 hardwired to zero, never written, never busy
- BYPASS, 1, 1 = a read returns same-cycle write data on address match

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- raddr  in  NRP*AW  read addresses; port k uses bits [k*AW +: AW]
- rdata  out  NRP*XLEN  read data; port k uses bits [k*XLEN +: XLEN]
- w0_en  in  1  write port 0 enable
- w0_addr  in  AW  write port 0 address
- w0_data  in  XLEN  write port 0 data
- w1_en  in  1  write port 1 enable (higher priority)
- w1_addr  in  AW  write port 1 address
- w1_data  in  XLEN  write port 1 data
- iss_en  in  1  issue: mark iss_addr busy
- iss_addr  in  AW  destination being issued
- busy  out  NREG  scoreboard, bit i = register i has a pending write
- init_done  out  1  high once the clear sequence has completed

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- FSM states: CLEAR, RUN.
- Reset:
  - rst=1 at an edge -> state=CLEAR, clear counter=0, busy=0, init_done=0.
  - rst has priority over all other inputs.
- CLEAR state:
  - Each cycle writes 0 to entry[counter], then increments the counter.
  - On the edge where counter==NREG-1 -> RUN, init_done=1 from the next cycle.
  - Clear therefore takes NREG cycles after rst deasserts.
  - w0/w1/iss are ignored; all rdata=0; busy stays 0.
- Reset mid-clear or mid-RUN: restarts the sequence from counter=0; all prior contents are considered lost.
- RUN state, writes:
  - wN_en=1 writes wN_data to entry[wN_addr] at the edge.
  - If ZERO_REG=1 and the address is 0, the write is dropped.
  - Both ports enabled to the same address: w1 wins; the w0 data is discarded.
- RUN state, reads:
  - Combinational, zero latency.
  - If ZERO_REG=1 and raddr==0 -> 0.
  - Else if BYPASS=1 and w1_en and w1_addr==raddr -> w1_data.
  - Else if BYPASS=1 and w0_en and w0_addr==raddr -> w0_data.
  - Else entry[raddr].
  - BYPASS=0: returns the stored value; new data is visible the cycle after the write.
- Scoreboard, RUN only:
  - iss_en sets busy[iss_addr] at the edge.
  - An enabled write on either port clears busy[wN_addr] at the edge.
  - Same-cycle set and clear on the same address: set wins (new producer in flight).
  - ZERO_REG=1: busy[0] is always 0.
  - Setting an already busy bit is legal and leaves it 1.
- Arithmetic: the counter is AW+1 bits wide so the terminal compare does not wrap; no other arithmetic.
- Outputs are defined every cycle; no X on rdata for any in-range address.

Test Plan:
- Reset clear: hold rst 2 cycles, release. init_done rises exactly 32 cycles later (NREG=32). Reading all 32 addresses then returns 0x00000000. Writes to x5 attempted during CLEAR are absent afterwards.
- Write/read and x0: after init, w0 writes x7=0xDEADBEEF and w1 writes x0=0x12345678. Next cycle, raddr0=7 -> 0xDEADBEEF and raddr1=0 -> 0.
- Port conflict and bypass: w0 (x3=0x11) and w1 (x3=0x22) in the same cycle with raddr2=3. rdata2 reads 0x22 in that cycle and 0x22 afterwards. With BYPASS=0 the same-cycle read returns the old value 0.
- Scoreboard: iss x9, then busy[9]=1 next cycle. Next, iss x9 and w0 x9 in the same cycle: busy[9] stays 1. Then w1 x9 alone: busy[9]=0. Issuing x0 never sets busy[0].
- Reset mid-operation: fill x1..x4 with nonzero values, set busy[2], assert rst for 1 cycle at counter midpoint. busy=0 immediately, init_done=0, full 32-cycle clear, then x1..x4 read 0.
- Parameter sweep: XLEN=64, NREG=16, AW=4, NRP=4, ZERO_REG=0. x0 is writable (0xFFFF0000FFFF0000 reads back). The clear takes 16 cycles, and all 4 read ports are independent.
